// File: rtl/ir_line_sensor_if.sv
// Signal bundle between the IR line sensor and its neighbours.
// The ADC side drives the channel values, and the motion side reads the decoded line state.
interface ir_line_sensor_if;
  logic [11:0] ir1;
  logic [11:0] ir2;
  logic [11:0] ir3;
  logic [2:0]  sensor_on;
  logic [2:0]  line_pos;
  logic        lost;
  logic        pos_valid;

  modport master (
    output ir1, ir2, ir3,
    input  sensor_on, line_pos, lost, pos_valid
  );

  modport slave (
    input  ir1, ir2, ir3,
    output sensor_on, line_pos, lost, pos_valid
  );
endinterface

// File: rtl/ir_line_sensor.sv
// Three-channel IR line sensor: tick sampling, block average, hysteresis and debounce,
// followed by line-position encoding with a one-cycle update strobe.
module ir_line_sensor #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned AVG_LOG2 = 2,
  parameter logic [11:0] TH_HI    = 12'd2300,
  parameter logic [11:0] TH_LO    = 12'd1800,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic clk_50,
  input  logic rst,
  ir_line_sensor_if.slave bus
);

  localparam int unsigned TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ACC_W  = 12 + AVG_LOG2;
  localparam int unsigned SCNT_W = AVG_LOG2 + 1;
  localparam int unsigned NSAMP  = 1 << AVG_LOG2;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE + 1);

  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_s;
  logic              s1_v_r;
  logic              blk_done_r;
  logic [11:0]       sample_r   [3];
  logic [ACC_W-1:0]  acc_r      [3];
  logic [SCNT_W-1:0] scnt_r;
  logic [2:0]        raw_on_r;
  logic [DEB_W-1:0]  deb_r      [3];
  logic [2:0]        sensor_on_r;
  logic [2:0]        line_pos_r;
  logic              lost_r;
  logic              pos_valid_r;

  logic [11:0]       avg_s      [3];
  logic [2:0]        raw_nxt_s;
  logic [2:0]        on_nxt_s;
  logic [DEB_W-1:0]  deb_nxt_s  [3];

  function automatic logic [2:0] enc_pos(input logic [2:0] on);
    logic [2:0] pos;
    case (on)
      3'b010:  pos = 3'b000;
      3'b011:  pos = 3'b001;
      3'b001:  pos = 3'b010;
      3'b110:  pos = 3'b101;
      3'b100:  pos = 3'b110;
      3'b111:  pos = 3'b011;
      3'b101:  pos = 3'b100;
      3'b000:  pos = 3'b111;
      default: pos = 3'b111;
    endcase
    return pos;
  endfunction

  assign tick_s = (tick_cnt_r == TICK_W'(CLK_DIV - 1));

  // Block average, hysteresis and debounce decision for the block just completed
  always_comb begin
    raw_nxt_s = raw_on_r;
    on_nxt_s  = sensor_on_r;
    for (int i = 0; i < 3; i++) begin
      avg_s[i]     = acc_r[i][AVG_LOG2 +: 12];
      deb_nxt_s[i] = deb_r[i];
      if (avg_s[i] > TH_HI) begin
        raw_nxt_s[i] = 1'b1;
      end else if (avg_s[i] < TH_LO) begin
        raw_nxt_s[i] = 1'b0;
      end else begin
        raw_nxt_s[i] = raw_on_r[i];
      end
      if (raw_nxt_s[i] != sensor_on_r[i]) begin
        if (deb_r[i] == DEB_W'(DEBOUNCE - 1)) begin
          on_nxt_s[i]  = ~sensor_on_r[i];
          deb_nxt_s[i] = {DEB_W{1'b0}};
        end else begin
          on_nxt_s[i]  = sensor_on_r[i];
          deb_nxt_s[i] = deb_r[i] + DEB_W'(1);
        end
      end else begin
        on_nxt_s[i]  = sensor_on_r[i];
        deb_nxt_s[i] = {DEB_W{1'b0}};
      end
    end
  end

  // Tick counter, sample capture, accumulation and registered outputs
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      tick_cnt_r  <= {TICK_W{1'b0}};
      s1_v_r      <= 1'b0;
      blk_done_r  <= 1'b0;
      scnt_r      <= {SCNT_W{1'b0}};
      raw_on_r    <= 3'b000;
      sensor_on_r <= 3'b000;
      line_pos_r  <= 3'b111;
      lost_r      <= 1'b1;
      pos_valid_r <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sample_r[i] <= 12'd0;
        acc_r[i]    <= {ACC_W{1'b0}};
        deb_r[i]    <= {DEB_W{1'b0}};
      end
    end else begin
      tick_cnt_r  <= tick_s ? {TICK_W{1'b0}} : tick_cnt_r + TICK_W'(1);
      s1_v_r      <= tick_s;
      blk_done_r  <= 1'b0;
      pos_valid_r <= blk_done_r;
      if (tick_s) begin
        sample_r[0] <= bus.ir1;
        sample_r[1] <= bus.ir2;
        sample_r[2] <= bus.ir3;
      end
      // The sample period is at least four cycles, so clearing and accumulating never coincide
      if (blk_done_r) begin
        scnt_r <= {SCNT_W{1'b0}};
        for (int i = 0; i < 3; i++) begin
          acc_r[i] <= {ACC_W{1'b0}};
        end
      end else if (s1_v_r) begin
        scnt_r     <= scnt_r + SCNT_W'(1);
        blk_done_r <= (scnt_r == SCNT_W'(NSAMP - 1));
        for (int i = 0; i < 3; i++) begin
          acc_r[i] <= acc_r[i] + ACC_W'(sample_r[i]);
        end
      end
      if (blk_done_r) begin
        raw_on_r    <= raw_nxt_s;
        sensor_on_r <= on_nxt_s;
        line_pos_r  <= enc_pos(on_nxt_s);
        lost_r      <= (on_nxt_s == 3'b000);
        for (int i = 0; i < 3; i++) begin
          deb_r[i] <= deb_nxt_s[i];
        end
      end
    end
  end

  assign bus.sensor_on = sensor_on_r;
  assign bus.line_pos  = line_pos_r;
  assign bus.lost      = lost_r;
  assign bus.pos_valid = pos_valid_r;

endmodule

// File: tb/tb_ir_line_sensor.sv
// Bench for ir_line_sensor: directed scenarios plus randomized inputs, checked every cycle
// against a block-level model of averaging, hysteresis and debounce.
module tb_ir_line_sensor;

  localparam int CLK_DIV  = 4;
  localparam int AVG_LOG2 = 2;
  localparam int DEBOUNCE = 2;
  localparam int TH_HI    = 2300;
  localparam int TH_LO    = 1800;
  localparam int NSAMP    = 1 << AVG_LOG2;
  localparam int BLK      = CLK_DIV * NSAMP;

  logic clk_50 = 1'b0;
  logic rst    = 1'b1;

  ir_line_sensor_if bus ();

  ir_line_sensor #(
    .CLK_DIV (CLK_DIV),
    .AVG_LOG2(AVG_LOG2),
    .TH_HI   (12'd2300),
    .TH_LO   (12'd1800),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk_50(clk_50),
    .rst   (rst),
    .bus   (bus)
  );

  always #10 clk_50 = ~clk_50;

  int errors = 0;
  int checks = 0;
  int cyc;
  int first_pv;

  int         m_sum [3];
  int         m_n;
  bit         m_raw [3];
  int         m_deb [3];
  logic [2:0] m_on;
  logic [2:0] m_pend;
  logic [2:0] m_shown;
  int         m_due;
  logic [2:0] pos_tab [8] = '{3'b111, 3'b010, 3'b000, 3'b001, 3'b110, 3'b100, 3'b101, 3'b011};

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0;
      m_raw[i] = 1'b0;
      m_deb[i] = 0;
    end
    m_n      = 0;
    m_on     = 3'b000;
    m_pend   = 3'b000;
    m_shown  = 3'b000;
    m_due    = -1;
    cyc      = 0;
    first_pv = -1;
  endtask

  task automatic set_ir(input int a, input int b, input int c);
    bus.ir1 = 12'(a);
    bus.ir2 = 12'(b);
    bus.ir3 = 12'(c);
  endtask

  // Observe the current cycle, advance the model, then move to the next cycle.
  task automatic step();
    int v [3];
    int avg;
    if (cyc == m_due) m_shown = m_pend;
    check_eq("pos_valid", int'(bus.pos_valid), int'(cyc == m_due));
    check_eq("sensor_on", int'(bus.sensor_on), int'(m_shown));
    check_eq("line_pos", int'(bus.line_pos), int'(pos_tab[m_shown]));
    check_eq("lost", int'(bus.lost), int'(m_shown == 3'b000));
    if (bus.pos_valid && first_pv < 0) first_pv = cyc;
    if (cyc % CLK_DIV == CLK_DIV - 1) begin
      v[0] = int'(bus.ir1);
      v[1] = int'(bus.ir2);
      v[2] = int'(bus.ir3);
      for (int i = 0; i < 3; i++) m_sum[i] += v[i];
      m_n++;
      if (m_n == NSAMP) begin
        for (int i = 0; i < 3; i++) begin
          avg = m_sum[i] / NSAMP;
          if (avg > TH_HI) m_raw[i] = 1'b1;
          else if (avg < TH_LO) m_raw[i] = 1'b0;
          if (m_raw[i] != m_on[i]) begin
            m_deb[i]++;
            if (m_deb[i] == DEBOUNCE) begin
              m_on[i]  = ~m_on[i];
              m_deb[i] = 0;
            end
          end else begin
            m_deb[i] = 0;
          end
          m_sum[i] = 0;
        end
        m_n    = 0;
        m_pend = m_on;
        m_due  = cyc + 3;
      end
    end
    @(negedge clk_50);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic align_block();
    while (cyc % BLK != 0) step();
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_50);
      check_eq("rst_sensor_on", int'(bus.sensor_on), 0);
      check_eq("rst_line_pos", int'(bus.line_pos), 7);
      check_eq("rst_lost", int'(bus.lost), 1);
      check_eq("rst_pos_valid", int'(bus.pos_valid), 0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int lvl [3];
    set_ir(4095, 4095, 4095);
    model_reset();

    // Reset and first two updates
    apply_reset(3);
    run(35);
    check_eq("t1_first_pv", first_pv, 18);
    check_eq("t1_sensor_on", int'(bus.sensor_on), 7);
    check_eq("t1_line_pos", int'(bus.line_pos), 3);
    check_eq("t1_lost", int'(bus.lost), 0);

    // Hysteresis band holds, below TH_LO releases
    set_ir(0, 2400, 0);
    run(3 * BLK);
    set_ir(0, 2000, 0);
    run(3 * BLK);
    check_eq("t2_hold_on", int'(bus.sensor_on[1]), 1);
    set_ir(0, 1799, 0);
    run(3 * BLK);
    check_eq("t2_off", int'(bus.sensor_on[1]), 0);

    // Equality with TH_HI never sets
    set_ir(2300, 0, 0);
    run(4 * BLK);
    check_eq("t3_eq_hold", int'(bus.sensor_on[0]), 0);
    set_ir(2301, 0, 0);
    run(4 * BLK);
    check_eq("t3_set", int'(bus.sensor_on[0]), 1);

    // Position decode
    set_ir(3000, 3000, 100);
    run(4 * BLK);
    check_eq("t4_slight_left", int'(bus.line_pos), 1);
    set_ir(100, 100, 3000);
    run(4 * BLK);
    check_eq("t4_right", int'(bus.line_pos), 6);

    // Single-block glitch is debounced away
    set_ir(0, 0, 0);
    run(4 * BLK);
    align_block();
    set_ir(0, 0, 4095);
    run(BLK);
    set_ir(0, 0, 0);
    run(3 * BLK);
    check_eq("t5_sensor_on", int'(bus.sensor_on), 0);
    check_eq("t5_lost", int'(bus.lost), 1);

    // Reset part-way through a block discards the partial sum
    set_ir(4095, 0, 0);
    align_block();
    run(9);
    apply_reset(2);
    run(20);
    check_eq("t6_first_pv", first_pv, 18);

    // Randomized levels near and away from the thresholds, with noise between ticks
    for (int i = 0; i < 3; i++) lvl[i] = 0;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 2))
            0:       lvl[i] = int'($urandom_range(0, 4095));
            1:       lvl[i] = int'($urandom_range(1700, 2400));
            default: lvl[i] = (lvl[i] > 2048) ? int'($urandom_range(0, 1000)) : int'($urandom_range(3000, 4095));
          endcase
        end
      end
      if (cyc % CLK_DIV == CLK_DIV - 1) set_ir(lvl[0], lvl[1], lvl[2]);
      else set_ir(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ir_line_sensor.md
Name: ir_line_sensor

Overview:
- Consumes the three 12-bit IR channel values produced by the ADC controller (ch5/ch6/ch7 = left/centre/right) in the clk_50 domain.
- Per channel, it applies a fixed-rate sampling tick, a block average, a hysteresis threshold and a debounce counter.
- It produces debounced on-line bits, an encoded line position, a lost flag and a one-cycle update strobe for the motion controller.
- It replaces the single fixed-threshold LED compare.

Parameters:
CLK_DIV, 50000, clk_50 cycles per sample tick (1 kHz at 50 MHz); must be ≥ 4
AVG_LOG2, 2, log2 of samples per block average (4 samples)
TH_HI, 12'd2300, average strictly above this turns a channel on
TH_LO, 12'd1800, average strictly below this turns a channel off
DEBOUNCE, 3, consecutive disagreeing averages required to change sensor_on (≥ 1)

Ports:
clk_50  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
ir1  in  12  left channel ADC value (ch5)
ir2  in  12  centre channel ADC value (ch6)
ir3  in  12  right channel ADC value (ch7)
sensor_on  out  3  debounced on-line bits; [0]=left, [1]=centre, [2]=right
line_pos  out  3  encoded line position (see Behaviour)
lost  out  1  high while sensor_on==3'b000
pos_valid  out  1  one-cycle strobe; sensor_on, line_pos and lost updated this cycle

Behaviour:
- Reset, asynchronous on rst high:
  - Outputs: sensor_on=0, line_pos=3'b111, lost=1, pos_valid=0.
  - Internal state: tick counter, sample counter, accumulators (12+AVG_LOG2 bits each), raw_on, debounce counters all 0.
  - A reset mid-block discards the partial accumulation; the first average after release uses 2^AVG_LOG2 fresh samples.
- Tick:
  - Counter runs 0..CLK_DIV-1 and wraps to 0.
  - tick=1 in the cycle the count equals CLK_DIV-1; the first tick is the CLK_DIV-th cycle after reset release.
- Pipeline, all registered, with T = tick cycle:
  - T: capture ir1..ir3 into sample registers.
  - T+1: add the samples to the accumulators and increment the sample counter. If this is the 2^AVG_LOG2-th sample, set block_done; the next cycle clears the accumulators and sample counter.
  - T+2, only on block_done: avg = acc >> AVG_LOG2, truncating (fits 12 bits).
    - Hysteresis per channel: raw_on 0→1 iff avg > TH_HI; raw_on 1→0 iff avg < TH_LO; otherwise hold.
    - Equality with either threshold holds the current state.
  - T+3, only on block_done:
    - If raw_on[i] != sensor_on[i], increment deb_cnt[i]. When the incremented value reaches DEBOUNCE, toggle sensor_on[i] and clear deb_cnt[i].
    - If raw_on[i] == sensor_on[i], clear deb_cnt[i].
    - line_pos and lost are registered from the new sensor_on in the same cycle; pos_valid=1 for exactly this cycle.
- Update interval: pos_valid occurs every CLK_DIV·2^AVG_LOG2 cycles, with no drift.
- line_pos encoding from sensor_on {R,C,L}:
  - 010→000 centre
  - 011→001 slight left
  - 001→010 left
  - 110→101 slight right
  - 100→110 right
  - 111→011 junction
  - 000→111 lost
  - 101→100 invalid/split
- Per-channel independence: each channel's averaging, hysteresis and debounce are independent. Simultaneous transitions on several channels update together in one pos_valid cycle.
- Inputs are sampled only on tick; changes between ticks are ignored.

Test Plan:
Use CLK_DIV=4, AVG_LOG2=2, DEBOUNCE=2, TH_HI=2300, TH_LO=1800. Cycle 0 is the first cycle after rst release. Ticks occur at 3,7,11,…; pos_valid occurs at 18, 34, 50, ….

1. Reset and first update: rst high with ir1..3=4095 → sensor_on=000, line_pos=111, lost=1, pos_valid=0 during reset. After release: pos_valid at 18 with sensor_on=000; pos_valid at 34 with sensor_on=111, line_pos=011, lost=0.
2. Hysteresis: ir2 held at 2400 until on, then 2000 for 3 blocks → sensor_on[1] stays 1. Then 1799 → sensor_on[1]=0 at the second following pos_valid.
3. Threshold equality: ir1 held at exactly 2300 for 4 blocks → sensor_on[0] never sets. Then 2301 → sets after 2 averages.
4. Position decode: after settle with ir1=ir2=3000, ir3=100 → line_pos=001. Then ir1=ir2=100, ir3=3000 → line_pos=110 after 2 averages.
5. Debounce glitch: all channels at 0, one block with ir3=4095 (all 4 samples), then 0 again → sensor_on stays 000, lost stays 1.
6. Reset mid-block: ir1=4095, assert rst for 2 cycles after 2 ticks of a block → the next pos_valid occurs at cycle 18 after release, not earlier.
